// File: rtl/idp_decoder_11_pkg.sv
// Shared constants and group-code helpers for the 11-bit IDP decoder.
// Holds the Fibonacci weights, the group-code offsets and the low-field bounds.
package idp_decoder_11_pkg;

    localparam int FNS01 = 1;
    localparam int FNS02 = 1;
    localparam int FNS03 = 2;
    localparam int FNS04 = 3;
    localparam int FNS05 = 5;
    localparam int FNS06 = 8;
    localparam int FNS07 = 13;
    localparam int FNS08 = 21;
    localparam int FNS09 = 34;
    localparam int FNS10 = 55;
    localparam int FNS11 = 89;
    localparam int FNS12 = 144;
    localparam int FNS13 = 233;

    localparam int IBLEN11 = 9;
    localparam int LOW_W   = 6;

    // Offsets of the ten legal MSB group codes.
    localparam logic [IBLEN11-1:0] IDP11_OFS_0000 = 9'd0;
    localparam logic [IBLEN11-1:0] IDP11_OFS_0001 = 9'(FNS08);
    localparam logic [IBLEN11-1:0] IDP11_OFS_1000 = 9'(FNS10);
    localparam logic [IBLEN11-1:0] IDP11_OFS_1001 = 9'(FNS10 + FNS08);
    localparam logic [IBLEN11-1:0] IDP11_OFS_0011 = 9'(FNS11 + FNS08);
    localparam logic [IBLEN11-1:0] IDP11_OFS_1100 = 9'(FNS12);
    localparam logic [IBLEN11-1:0] IDP11_OFS_0110 = 9'(FNS12 + FNS09);
    localparam logic [IBLEN11-1:0] IDP11_OFS_0111 = 9'(FNS12 + FNS09 + FNS08);
    localparam logic [IBLEN11-1:0] IDP11_OFS_1110 = 9'(FNS13);
    localparam logic [IBLEN11-1:0] IDP11_OFS_1111 = 9'(FNS13 + FNS08);

    localparam logic [LOW_W-1:0] IDP11_LOW_MIN_HI = 6'd13;
    localparam logic [LOW_W-1:0] IDP11_LOW_MAX_LO = 6'd20;
    localparam logic [LOW_W-1:0] IDP11_LOW_MAX    = 6'd33;

    typedef enum logic [1:0] {
        RNG_NONE,
        RNG_FULL,
        RNG_UPPER,
        RNG_LOWER
    } low_rng_e;

    function automatic logic [IBLEN11-1:0] grp_offset(input logic [3:0] grp);
        case (grp)
            4'b0000: return IDP11_OFS_0000;
            4'b0001: return IDP11_OFS_0001;
            4'b1000: return IDP11_OFS_1000;
            4'b1001: return IDP11_OFS_1001;
            4'b0011: return IDP11_OFS_0011;
            4'b1100: return IDP11_OFS_1100;
            4'b0110: return IDP11_OFS_0110;
            4'b0111: return IDP11_OFS_0111;
            4'b1110: return IDP11_OFS_1110;
            4'b1111: return IDP11_OFS_1111;
            default: return '0;
        endcase
    endfunction

    // Groups 0001/1001 only carry the upper part of the low range, 0110/1110 the lower part.
    function automatic low_rng_e grp_range(input logic [3:0] grp);
        case (grp)
            4'b0001, 4'b1001:                               return RNG_UPPER;
            4'b0110, 4'b1110:                               return RNG_LOWER;
            4'b0000, 4'b1000, 4'b0011, 4'b1100, 4'b0111,
            4'b1111:                                        return RNG_FULL;
            default:                                        return RNG_NONE;
        endcase
    endfunction

    function automatic logic grp_legal(input logic [3:0] grp, input logic [LOW_W-1:0] low);
        case (grp_range(grp))
            RNG_UPPER: return (low >= IDP11_LOW_MIN_HI) && (low <= IDP11_LOW_MAX);
            RNG_LOWER: return (low <= IDP11_LOW_MAX_LO);
            RNG_FULL:  return (low <= IDP11_LOW_MAX);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fns_lsb_sum_7.sv
// Combinational weighted sum of a 7-bit Fibonacci (FNS) low field, 0..33.
// Shared by the IDP decoders of every width that use a 7-bit low field.
module fns_lsb_sum_7
    import idp_decoder_11_pkg::*;
(
    input  logic [6:0]       fns_i,
    output logic [LOW_W-1:0] sum_o
);

    assign sum_o = (fns_i[6] ? 6'(FNS07) : 6'd0)
                 + (fns_i[5] ? 6'(FNS06) : 6'd0)
                 + (fns_i[4] ? 6'(FNS05) : 6'd0)
                 + (fns_i[3] ? 6'(FNS04) : 6'd0)
                 + (fns_i[2] ? 6'(FNS03) : 6'd0)
                 + (fns_i[1] ? 6'(FNS02) : 6'd0)
                 + (fns_i[0] ? 6'(FNS01) : 6'd0);

endmodule

// File: rtl/idp_decoder_11.sv
// Two-stage decoder from the 11-bit IDP codeword to the 9-bit data word 0..287.
// Define IDP_DEC_CHECK_EN to build the illegal-codeword flag and saturating counter.
module idp_decoder_11
    import idp_decoder_11_pkg::*;
#(
    parameter int ERRCNT_W = 8
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic [10:0]         codein,
    input  logic                valid_in,
    output logic [IBLEN11-1:0]  dataout,
    output logic                valid_out
`ifdef IDP_DEC_CHECK_EN
    ,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    logic [IBLEN11-1:0] ofs_d, ofs_q;
    logic [LOW_W-1:0]   low_d, low_q;
    logic               v1_q;
    logic [IBLEN11-1:0] data_d, data_q;
    logic               vout_q;

    assign ofs_d = grp_offset(codein[10:7]);

    fns_lsb_sum_7 u_low_sum (
        .fns_i (codein[6:0]),
        .sum_o (low_d)
    );

    // Stage 1: capture the group offset and low sum of each valid codeword.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q  <= 1'b0;
            ofs_q <= '0;
            low_q <= '0;
        end else begin
            v1_q <= valid_in;
            if (valid_in) begin
                ofs_q <= ofs_d;
                low_q <= low_d;
            end
        end
    end

    assign data_d = ofs_q + {{(IBLEN11-LOW_W){1'b0}}, low_q};

    // Stage 2: add; bubbles leave the last decoded word on the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            vout_q <= 1'b0;
        end else begin
            vout_q <= v1_q;
            if (v1_q) begin
                data_q <= data_d;
            end
        end
    end

    assign dataout   = data_q;
    assign valid_out = vout_q;

`ifdef IDP_DEC_CHECK_EN
    logic                legal_d, legal_q;
    logic                err_q;
    logic [ERRCNT_W-1:0] cnt_d, cnt_q;

    assign legal_d = grp_legal(codein[10:7], low_d);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            legal_q <= 1'b0;
        end else if (valid_in) begin
            legal_q <= legal_d;
        end
    end

    // The counter sticks at all-ones rather than wrapping.
    assign cnt_d = (v1_q && !legal_q && (cnt_q != {ERRCNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (v1_q) begin
                err_q <= !legal_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign err       = err_q;
    assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_idp_decoder_11.sv
// Bench for idp_decoder_11: constant vectors, full legal sweep, random traffic and reset.
// Honours IDP_DEC_CHECK_EN the same way as the design.
module tb_idp_decoder_11;

    localparam int ERRCNT_W = 8;
    localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] codein = '0;
    logic        valid_in = 1'b0;
    logic [8:0]  dataout;
    logic        valid_out;
`ifdef IDP_DEC_CHECK_EN
    logic                err;
    logic [ERRCNT_W-1:0] err_count;
`endif

    idp_decoder_11 #(.ERRCNT_W(ERRCNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .codein    (codein),
        .valid_in  (valid_in),
        .dataout   (dataout),
        .valid_out (valid_out)
`ifdef IDP_DEC_CHECK_EN
        ,
        .err       (err),
        .err_count (err_count)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    int ofs_tab [16];
    int lo_tab  [16];
    int hi_tab  [16];
    bit ok_tab  [16];
    int wt      [7];

    // Output-side view of the pipeline: what was sampled one edge ago, and what is held.
    bit          m_prev_v;
    logic [10:0] m_prev_code;
    bit          m_vout;
    int          m_data;
    bit          m_err;
    int          m_cnt;

    typedef struct {
        logic [10:0] code;
        int          data;
        bit          err;
        int          cnt;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [10:0] code, output int data, output bit bad);
        int g;
        int low;
        g   = int'(code[10:7]);
        low = 0;
        for (int i = 0; i < 7; i++) if (code[i]) low += wt[i];
        data = (ok_tab[g] ? ofs_tab[g] : 0) + low;
        bad  = !ok_tab[g] || (low < lo_tab[g]) || (low > hi_tab[g]);
    endfunction

    function automatic logic [10:0] ref_encode(input int d);
        int          best_g;
        int          rem;
        logic [6:0]  bits;
        best_g = -1;
        for (int g = 0; g < 16; g++) begin
            if (ok_tab[g] && d >= ofs_tab[g] && d - ofs_tab[g] >= lo_tab[g] &&
                d - ofs_tab[g] <= hi_tab[g]) begin
                if (best_g < 0 || ofs_tab[g] > ofs_tab[best_g]) best_g = g;
            end
        end
        if (best_g < 0) best_g = 0;
        rem  = d - ofs_tab[best_g];
        bits = '0;
        for (int i = 6; i >= 0; i--) begin
            if (rem >= wt[i]) begin
                bits[i] = 1'b1;
                rem -= wt[i];
            end
        end
        return {best_g[3:0], bits};
    endfunction

    task automatic model_clear();
        m_prev_v = 0; m_prev_code = '0; m_vout = 0; m_data = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic step(input bit v, input logic [10:0] c);
        int d;
        bit b;
        valid_in = v;
        codein   = c;
        @(posedge clock);
        #1;
        if (reset) begin
            model_clear();
        end else begin
            m_vout = m_prev_v;
            if (m_prev_v) begin
                ref_decode(m_prev_code, d, b);
                m_data = d;
                m_err  = b;
                if (b && m_cnt < CNT_MAX) m_cnt++;
            end
            m_prev_v    = v;
            m_prev_code = c;
        end
        chk("valid_out", int'(valid_out), int'(m_vout));
        chk("dataout", int'(dataout), m_data);
`ifdef IDP_DEC_CHECK_EN
        chk("err", int'(err), int'(m_err));
        chk("err_count", int'(err_count), m_cnt);
`endif
    endtask

    initial begin
        ofs_tab = '{default: 0};
        lo_tab  = '{default: 0};
        hi_tab  = '{default: 33};
        ok_tab  = '{default: 0};
        wt      = '{1, 1, 2, 3, 5, 8, 13};
        ofs_tab[4'b0000] = 0;   ok_tab[4'b0000] = 1;
        ofs_tab[4'b0001] = 21;  ok_tab[4'b0001] = 1; lo_tab[4'b0001] = 13;
        ofs_tab[4'b1000] = 55;  ok_tab[4'b1000] = 1;
        ofs_tab[4'b1001] = 76;  ok_tab[4'b1001] = 1; lo_tab[4'b1001] = 13;
        ofs_tab[4'b0011] = 110; ok_tab[4'b0011] = 1;
        ofs_tab[4'b1100] = 144; ok_tab[4'b1100] = 1;
        ofs_tab[4'b0110] = 178; ok_tab[4'b0110] = 1; hi_tab[4'b0110] = 20;
        ofs_tab[4'b0111] = 199; ok_tab[4'b0111] = 1;
        ofs_tab[4'b1110] = 233; ok_tab[4'b1110] = 1; hi_tab[4'b1110] = 20;
        ofs_tab[4'b1111] = 254; ok_tab[4'b1111] = 1;

        vecs[0] = '{11'h000, 0,   1'b0, 0};
        vecs[1] = '{11'h7FF, 287, 1'b0, 0};
        vecs[2] = '{11'h4E6, 100, 1'b0, 0};
        vecs[3] = '{11'h200, 0,   1'b1, 1};
        vecs[4] = '{11'h37F, 211, 1'b1, 2};
        vecs[5] = '{11'h080, 21,  1'b1, 3};
        vecs[6] = '{11'h300, 178, 1'b0, 3};

        model_clear();

        // Reset is already high: outputs must be zero without any edge.
        #1;
        chk("reset_valid_out", int'(valid_out), 0);
        chk("reset_dataout", int'(dataout), 0);
`ifdef IDP_DEC_CHECK_EN
        chk("reset_err", int'(err), 0);
        chk("reset_err_count", int'(err_count), 0);
`endif
        step(0, '0);
        step(0, '0);
        #2 reset = 1'b0;
        step(0, '0);

        foreach (vecs[i]) begin
            step(1, vecs[i].code);
            step(0, '0);
            chk("vec_valid", int'(valid_out), 1);
            chk("vec_data", int'(dataout), vecs[i].data);
`ifdef IDP_DEC_CHECK_EN
            chk("vec_err", int'(err), int'(vecs[i].err));
            chk("vec_err_count", int'(err_count), vecs[i].cnt);
`endif
        end

        // Saturation: 300 illegal words on top of the three already counted.
        for (int i = 0; i < 300; i++) step(1, 11'h200);
        step(0, '0);
        step(0, '0);
`ifdef IDP_DEC_CHECK_EN
        chk("sat_err_count", int'(err_count), CNT_MAX);
`endif

        // Every data value, back to back.
        for (int d = 0; d < 290; d++) begin
            step(d < 288, (d < 288) ? ref_encode(d) : 11'h000);
            if (d >= 1 && d <= 288) begin
                chk("stream_valid", int'(valid_out), 1);
                chk("stream_data", int'(dataout), d - 1);
`ifdef IDP_DEC_CHECK_EN
                chk("stream_err", int'(err), 0);
`endif
            end
        end

        for (int i = 0; i < 500; i++) begin
            step(bit'($urandom_range(0, 3) != 0), 11'($urandom));
        end

        // Reset between edges in the middle of a stream.
        step(1, ref_encode(250));
        step(1, ref_encode(77));
        step(1, ref_encode(31));
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid_out", int'(valid_out), 0);
        chk("midrst_dataout", int'(dataout), 0);
`ifdef IDP_DEC_CHECK_EN
        chk("midrst_err_count", int'(err_count), 0);
`endif
        model_clear();
        step(0, '0);
        #2 reset = 1'b0;
        step(1, ref_encode(123));
        step(0, '0);
        chk("post_rst_valid", int'(valid_out), 1);
        chk("post_rst_data", int'(dataout), 123);
        step(0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idp_decoder_11.md
# idp_decoder_11

Pipelined decoder for the 11-bit IDP crosstalk-avoidance codeword, the receive-side counterpart of the 11-bit IDP encoder. It takes a registered codeword from the bus: a 4-bit MSB group code plus a 7-bit Fibonacci (FNS) low field. It returns the 9-bit data word, 0..287, after two clock edges. An optional checker flags codewords the encoder can never produce and counts them.

## Interface
- `ERRCNT_W`, default 8: width of the saturating error counter. Used only with `IDP_DEC_CHECK_EN`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `codein` in 11: received codeword. Bits [10:7] are the MSB group code; bits [6:0] are the FNS low field.
- `valid_in` in 1: `codein` is meaningful this cycle. There is no backpressure.
- `dataout` out 9 (`IBLEN11`): decoded data. Reset value 0.
- `valid_out` out 1: `dataout` is valid. Reset value 0.
- `err` out 1: codeword illegal, aligned with `valid_out`. Reset value 0. Present only with `IDP_DEC_CHECK_EN`.
- `err_count` out `ERRCNT_W`: saturating count of illegal codewords. Reset value 0. Present only with `IDP_DEC_CHECK_EN`.

## Operation
- Low-field weights, bit6..bit0: FNS07..FNS01 = 13, 8, 5, 3, 2, 1, 1.
  - low = Σ bit·weight, range 0..33, 6 bits.
- MSB group code to offset (`FNS` constants: FNS08=21, FNS10=55, FNS11=89):
  - 0000→0, 0001→21, 1000→55, 1001→76, 0011→110
  - 1100→144, 0110→178, 0111→199, 1110→233, 1111→254
- The six other group codes are illegal. Their offset is 0.
- dataout = offset + low, 9-bit unsigned. The maximum is 254 + 33 = 287, so the result never overflows.
- Stage 1, on a `valid_in` edge: register offset (9b), low (6b) and the legality flag; `v1` <= `valid_in`.
- Stage 2: `dataout` <= offset + low; `valid_out` <= `v1`.
- When `v1` = 0, `dataout` holds its previous value. Pipeline bubbles pass through unchanged.
- Back-to-back `valid_in` sustains one word per cycle.
- Low-field legality for each group:
  - 0001 and 1001: low must be 13..33.
  - 0110 and 1110: low must be 0..20.
  - All other legal groups: low must be 0..33.
- The decoder reconstructs data exactly for every legal codeword. No knowledge of the encoder's ambiguity-resolution bit is needed.

## Timing
- Latency is 2 edges: `codein` sampled at edge N appears on `dataout`/`valid_out` after edge N+1.
- `reset` asserted at any time:
  - `v1`, `valid_out`, `dataout`, `err` and `err_count` go to 0 immediately.
  - Any words in flight are discarded.
- On reset release, the first `valid_in` edge produces `valid_out` one edge later.
- `err` is updated only on edges where `v1` = 1 and holds otherwise, like `dataout`.
- `err_count` increments on the edge where `err` is set. It saturates at 2^`ERRCNT_W` − 1 and never wraps.

## Configuration
- `IDP_DEC_CHECK_EN` defined:
  - The group-code and low-range checker is built.
  - `err` and `err_count` ports exist.
  - An illegal codeword still produces `dataout` = offset + low, with offset 0 for illegal groups, and `valid_out` = 1.
- `IDP_DEC_CHECK_EN` undefined:
  - No checker logic, no legality register, no `err`/`err_count` ports.
  - Illegal group codes decode with offset 0, silently.

## Structure
- Existing `FNS.vh`: `FNS01`..`FNS13` and `IBLEN11`.
- Add to `FNS.vh`: the ten group-code offsets as `IDP11_OFS_<code>` constants, plus the low-range bounds 13, 20 and 33.
- Sub-module `fns_lsb_sum_7`: combinational 7-bit FNS weighted summer, reusable by other IDP decoder widths.
- Top level holds the group-code lookup, the pipeline registers and the checker/counter.

## Test plan
- Reset, then `codein` 0x000 with `valid_in` → `dataout` 0, `valid_out` 1 two edges later.
- `codein` 0x7FF (1111_1111111) → `dataout` 287.
- `codein` 0x4E6 (1001_1100110) → `dataout` 100.
- Stream every legal 0..287 encoding back-to-back:
  - `dataout` equals the input sequence, one word per cycle, 2-cycle latency.
  - No `err`.
- With `IDP_DEC_CHECK_EN`, two illegal codewords:
  - 0x200 (group 0100) → `err` 1, `err_count` 1.
  - 0x37F (group 0110, low 33) → `err` 1, `err_count` 2.
  - 300 illegal words → `err_count` 255 with `ERRCNT_W` = 8.
- Assert `reset` mid-stream between edges:
  - `valid_out`, `dataout` and `err_count` go to 0 without waiting for a clock edge.
  - After release, the next valid word decodes correctly.
